// File: rtl/avalon_st_pkg.sv
// Shared Avalon-ST definitions: serializer state encodings and beat-count helper.
// Used by the width converters that sit downstream of the packet FIFO.
package avalon_st_pkg;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_SERIAL = 1'b1;

   // Number of beat_bytes-wide beats needed to carry n_bytes (ceiling division).
   function automatic int unsigned beats_for_bytes(input int unsigned n_bytes,
                                                   input int unsigned beat_bytes);
      return (n_bytes + beat_bytes - 1) / beat_bytes;
   endfunction

endpackage

// File: rtl/avalon_st_width_downsizer.sv
// Serializes one wide Avalon-ST word at a time into RATIO narrow beats, first symbol in MSBs.
// Preserves sop/eop/channel, trims the final beat by empty and flags packet framing errors.
module avalon_st_width_downsizer
   import avalon_st_pkg::*;
#(
   parameter int unsigned IN_DATA_WIDTH  = 64,
   parameter int unsigned OUT_DATA_WIDTH = 16,
   parameter int unsigned CHANNEL_WIDTH  = 8,
   localparam int unsigned IN_B        = IN_DATA_WIDTH / 8,
   localparam int unsigned OUT_B       = OUT_DATA_WIDTH / 8,
   localparam int unsigned RATIO       = IN_DATA_WIDTH / OUT_DATA_WIDTH,
   localparam int unsigned IN_EMPTY_W  = (IN_B > 1) ? $clog2(IN_B) : 1,
   localparam int unsigned OUT_EMPTY_W = (OUT_B > 1) ? $clog2(OUT_B) : 1,
   localparam int unsigned BEAT_W      = $clog2(RATIO)
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   // wide sink
   input  logic                      pkt_i_valid,
   output logic                      pkt_i_ready,
   input  logic [IN_DATA_WIDTH-1:0]  pkt_i_data,
   input  logic                      pkt_i_startofpacket,
   input  logic                      pkt_i_endofpacket,
   input  logic [IN_EMPTY_W-1:0]     pkt_i_empty,
   input  logic [CHANNEL_WIDTH-1:0]  pkt_i_channel,
   // narrow source
   output logic                      pkt_o_valid,
   input  logic                      pkt_o_ready,
   output logic [OUT_DATA_WIDTH-1:0] pkt_o_data,
   output logic                      pkt_o_startofpacket,
   output logic                      pkt_o_endofpacket,
   output logic [OUT_EMPTY_W-1:0]    pkt_o_empty,
   output logic [CHANNEL_WIDTH-1:0]  pkt_o_channel,
   // status
   output logic                      busy_o,
   output logic                      proto_err_o
);

   localparam int unsigned BEAT_CW = (BEAT_W > 0) ? BEAT_W : 1;
   localparam int unsigned NB_W    = BEAT_W + 1;

   typedef struct packed {
      logic [IN_DATA_WIDTH-1:0] data;
      logic [IN_EMPTY_W-1:0]    empty;
      logic                     sop;
      logic                     eop;
      logic [CHANNEL_WIDTH-1:0] channel;
   } word_t;

   word_t                              in_word;
   word_t                              held_q;
   logic [0:0]                         state_q;
   logic [BEAT_CW-1:0]                 beat_cnt_q;
   logic                               in_pkt_q;
   logic                               err_q;

   logic                               busy;
   logic                               accept;
   logic                               out_hs;
   logic                               last_beat;
   logic [NB_W-1:0]                    n_beats;
   logic [31:0]                        empty_sat;
   logic [31:0]                        valid_bytes;
   logic [31:0]                        beats_full;
   logic [31:0]                        pad_bytes;
   logic [BEAT_CW-1:0]                 beat_sel;
   logic [RATIO-1:0][OUT_DATA_WIDTH-1:0] beat_view;

   always_comb begin
      in_word         = '0;
      in_word.data    = pkt_i_data;
      in_word.empty   = pkt_i_empty;
      in_word.sop     = pkt_i_startofpacket;
      in_word.eop     = pkt_i_endofpacket;
      in_word.channel = pkt_i_channel;
   end

   // Beat count and last-beat padding derived from the held word; empty saturates
   // so an eop word always carries at least one valid byte.
   always_comb begin
      empty_sat = 32'(held_q.empty);
      if (empty_sat > IN_B - 1) begin
         empty_sat = IN_B - 1;
      end
      valid_bytes = IN_B - empty_sat;
      beats_full  = held_q.eop ? beats_for_bytes(valid_bytes, OUT_B) : RATIO;
      pad_bytes   = beats_full * OUT_B - valid_bytes;
      n_beats     = NB_W'(beats_full);
      last_beat   = (NB_W'(beat_cnt_q) == n_beats - NB_W'(1));
   end

   assign busy        = (state_q == ST_SERIAL);
   assign out_hs      = busy && pkt_o_ready;
   assign pkt_i_ready = !busy || (out_hs && last_beat);
   assign accept      = pkt_i_valid && pkt_i_ready;

   // Packed view: beat k sits at index RATIO-1-k so beat 0 is the MSB slice.
   assign beat_view = held_q.data;
   assign beat_sel  = BEAT_CW'(RATIO - 1) - beat_cnt_q;

   assign pkt_o_valid         = busy;
   assign pkt_o_data          = beat_view[beat_sel];
   assign pkt_o_startofpacket = held_q.sop && (beat_cnt_q == '0);
   assign pkt_o_endofpacket   = held_q.eop && last_beat;
   assign pkt_o_empty         = pkt_o_endofpacket ? OUT_EMPTY_W'(pad_bytes) : '0;
   assign pkt_o_channel       = held_q.channel;
   assign busy_o              = busy;
   assign proto_err_o         = err_q;

   always_ff @(posedge clk_i) begin
      if (accept) begin
         held_q <= in_word;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         beat_cnt_q <= '0;
      end else if (accept) begin
         state_q    <= ST_SERIAL;
         beat_cnt_q <= '0;
      end else if (out_hs) begin
         if (last_beat) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
         end else begin
            beat_cnt_q <= beat_cnt_q + BEAT_CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         in_pkt_q <= 1'b0;
         err_q    <= 1'b0;
      end else if (accept) begin
         if (pkt_i_startofpacket == in_pkt_q) begin
            err_q <= 1'b1;
         end
         if (pkt_i_endofpacket) begin
            in_pkt_q <= 1'b0;
         end else if (pkt_i_startofpacket) begin
            in_pkt_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_avalon_st_width_downsizer.sv
// Bench for the 64->16 downsizer: directed framing/empty/reset cases plus random
// packets under random backpressure, scored against a byte-level reference model.
module tb_avalon_st_width_downsizer;

   localparam int IN_W  = 64;
   localparam int OUT_W = 16;
   localparam int CH_W  = 8;
   localparam int IN_B  = IN_W / 8;
   localparam int OUT_B = OUT_W / 8;

   logic             clk_i = 1'b0;
   logic             rst_n_i;
   logic             pkt_i_valid;
   logic             pkt_i_ready;
   logic [IN_W-1:0]  pkt_i_data;
   logic             pkt_i_startofpacket;
   logic             pkt_i_endofpacket;
   logic [2:0]       pkt_i_empty;
   logic [CH_W-1:0]  pkt_i_channel;
   logic             pkt_o_valid;
   logic             pkt_o_ready;
   logic [OUT_W-1:0] pkt_o_data;
   logic             pkt_o_startofpacket;
   logic             pkt_o_endofpacket;
   logic [0:0]       pkt_o_empty;
   logic [CH_W-1:0]  pkt_o_channel;
   logic             busy_o;
   logic             proto_err_o;

   avalon_st_width_downsizer #(
      .IN_DATA_WIDTH (IN_W),
      .OUT_DATA_WIDTH(OUT_W),
      .CHANNEL_WIDTH (CH_W)
   ) dut (
      .clk_i              (clk_i),
      .rst_n_i            (rst_n_i),
      .pkt_i_valid        (pkt_i_valid),
      .pkt_i_ready        (pkt_i_ready),
      .pkt_i_data         (pkt_i_data),
      .pkt_i_startofpacket(pkt_i_startofpacket),
      .pkt_i_endofpacket  (pkt_i_endofpacket),
      .pkt_i_empty        (pkt_i_empty),
      .pkt_i_channel      (pkt_i_channel),
      .pkt_o_valid        (pkt_o_valid),
      .pkt_o_ready        (pkt_o_ready),
      .pkt_o_data         (pkt_o_data),
      .pkt_o_startofpacket(pkt_o_startofpacket),
      .pkt_o_endofpacket  (pkt_o_endofpacket),
      .pkt_o_empty        (pkt_o_empty),
      .pkt_o_channel      (pkt_o_channel),
      .busy_o             (busy_o),
      .proto_err_o        (proto_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [OUT_W-1:0] data;
      int               nvalid;
      bit               sop;
      bit               eop;
      int               empty;
      logic [CH_W-1:0]  ch;
   } beat_t;

   beat_t exp_q[$];
   int    total = 0;
   int    bad = 0;
   int    beats_seen = 0;
   int    cyc = 0;
   int    sop_cyc = 0;
   int    eop_cyc = 0;
   int    last_empty = -1;
   bit    last_eop = 1'b0;
   bit    rand_ready = 1'b0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ready();
      pkt_o_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   // Reference model: cut the word into bytes (first symbol = MSB byte) and
   // deal them out OUT_B at a time until the valid bytes run out.
   task automatic model_word(input logic [IN_W-1:0] d, input bit sop, input bit eop,
                             input int empty, input logic [CH_W-1:0] ch);
      logic [7:0] bytes[IN_B];
      int         vb;
      for (int i = 0; i < IN_B; i++) bytes[i] = d[IN_W-1-8*i -: 8];
      vb = eop ? IN_B - ((empty > IN_B - 1) ? IN_B - 1 : empty) : IN_B;
      for (int first = 0; first < vb; first += OUT_B) begin
         beat_t b;
         b.data = '0;
         for (int j = 0; j < OUT_B; j++) b.data[OUT_W-1-8*j -: 8] = bytes[first+j];
         b.nvalid = (vb - first < OUT_B) ? vb - first : OUT_B;
         b.sop    = sop && (first == 0);
         b.eop    = eop && (first + OUT_B >= vb);
         b.empty  = b.eop ? OUT_B - b.nvalid : 0;
         b.ch     = ch;
         exp_q.push_back(b);
      end
   endtask

   always @(negedge clk_i) begin
      if (rst_n_i && pkt_o_valid && pkt_o_ready) begin
         beat_t            e;
         logic [OUT_W-1:0] m;
         beats_seen++;
         if (pkt_o_startofpacket) sop_cyc = cyc;
         if (pkt_o_endofpacket) begin
            eop_cyc    = cyc;
            last_empty = int'(pkt_o_empty);
         end
         last_eop = pkt_o_endofpacket;
         chk("beat_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            m = '0;
            for (int j = 0; j < e.nvalid; j++) m[OUT_W-1-8*j -: 8] = 8'hff;
            chk("data", pkt_o_data & m, e.data & m);
            chk("sop", pkt_o_startofpacket, e.sop);
            chk("eop", pkt_o_endofpacket, e.eop);
            chk("empty", pkt_o_empty, e.empty);
            chk("channel", pkt_o_channel, e.ch);
         end
      end
   end

   task automatic drive_word(input logic [IN_W-1:0] d, input bit sop, input bit eop,
                             input logic [2:0] empty, input logic [CH_W-1:0] ch);
      int waited = 0;
      bit done = 1'b0;
      pkt_i_valid         = 1'b1;
      pkt_i_data          = d;
      pkt_i_startofpacket = sop;
      pkt_i_endofpacket   = eop;
      pkt_i_empty         = empty;
      pkt_i_channel       = ch;
      while (!done && waited < 200) begin
         @(negedge clk_i);
         if (pkt_i_ready) begin
            model_word(d, sop, eop, int'(empty), ch);
            done = 1'b1;
         end
         @(posedge clk_i);
         #1;
         set_ready();
         waited++;
      end
      pkt_i_valid = 1'b0;
      chk("word_accepted", done, 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
         set_ready();
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy_o) && n < 500) begin
         @(posedge clk_i);
         #1;
         set_ready();
         n++;
      end
      chk("drain_queue", exp_q.size(), 0);
      chk("drain_idle", busy_o, 0);
   endtask

   initial begin
      int s;
      rst_n_i             = 1'b0;
      pkt_i_valid         = 1'b0;
      pkt_i_data          = '0;
      pkt_i_startofpacket = 1'b0;
      pkt_i_endofpacket   = 1'b0;
      pkt_i_empty         = '0;
      pkt_i_channel       = '0;
      set_ready();
      #1;
      chk("rst_valid", pkt_o_valid, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_err", proto_err_o, 0);
      chk("rst_in_ready", pkt_i_ready, 1);
      #21 rst_n_i = 1'b1;
      @(posedge clk_i);
      #1;

      // 4-word packet, full words, sink always ready: 16 beats with no gaps
      s = beats_seen;
      drive_word(64'h0011_2233_4455_6677, 1'b1, 1'b0, 3'd0, 8'h3c);
      drive_word(64'h8899_aabb_ccdd_eeff, 1'b0, 1'b0, 3'd6, 8'h3c);
      drive_word(64'h0123_4567_89ab_cdef, 1'b0, 1'b0, 3'd0, 8'h3c);
      drive_word(64'hfedc_ba98_7654_3210, 1'b0, 1'b1, 3'd0, 8'h3c);
      drain();
      chk("t1_beats", beats_seen - s, 16);
      chk("t1_span", eop_cyc - sop_cyc, 15);
      chk("t1_last_empty", last_empty, 0);

      // eop word with 3 valid bytes -> 2 beats, last beat has one pad byte
      s = beats_seen;
      drive_word(64'h1020_3040_5060_7080, 1'b1, 1'b0, 3'd0, 8'h01);
      drive_word(64'ha1b2_c3d4_e5f6_0718, 1'b0, 1'b1, 3'd5, 8'h01);
      drain();
      chk("t2_beats", beats_seen - s, 6);
      chk("t2_last_empty", last_empty, 1);
      chk("t2_last_eop", last_eop, 1);

      // single-word packet with one valid byte -> one beat
      s = beats_seen;
      drive_word(64'h5a00_0000_0000_0000, 1'b1, 1'b1, 3'd7, 8'h7e);
      drain();
      chk("t3_beats", beats_seen - s, 1);
      chk("t3_last_empty", last_empty, 1);
      chk("t3_err_clean", proto_err_o, 0);

      // random packets under 50% sink backpressure
      rand_ready = 1'b1;
      for (int p = 0; p < 100; p++) begin
         int              len;
         logic [CH_W-1:0] ch;
         len = $urandom_range(1, 5);
         ch  = CH_W'($urandom);
         for (int w = 0; w < len; w++) begin
            drive_word({$urandom, $urandom}, w == 0, w == len - 1, 3'($urandom), ch);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         end
      end
      drain();
      chk("t4_err_clean", proto_err_o, 0);

      // sop inside a packet: error latches, words still forwarded
      rand_ready = 1'b0;
      set_ready();
      drive_word(64'h1111_2222_3333_4444, 1'b1, 1'b0, 3'd0, 8'h22);
      chk("t5_err_before", proto_err_o, 0);
      drive_word(64'h5555_6666_7777_8888, 1'b1, 1'b0, 3'd0, 8'h22);
      chk("t5_err_set", proto_err_o, 1);
      drive_word(64'h9999_aaaa_bbbb_cccc, 1'b0, 1'b1, 3'd2, 8'h22);
      drain();
      idle(5);
      chk("t5_err_sticky", proto_err_o, 1);

      // reset mid-serialization
      drive_word(64'hdead_beef_cafe_f00d, 1'b1, 1'b0, 3'd0, 8'h44);
      idle(1);
      chk("t6_busy_before", busy_o, 1);
      #2 rst_n_i = 1'b0;
      #1;
      chk("t6_valid_reset", pkt_o_valid, 0);
      chk("t6_busy_reset", busy_o, 0);
      chk("t6_err_reset", proto_err_o, 0);
      exp_q.delete();
      #14 rst_n_i = 1'b1;
      @(posedge clk_i);
      #1;
      set_ready();
      chk("t6_in_ready", pkt_i_ready, 1);
      s = beats_seen;
      drive_word(64'h0102_0304_0506_0708, 1'b1, 1'b0, 3'd0, 8'h55);
      drive_word(64'h090a_0b0c_0d0e_0f10, 1'b0, 1'b1, 3'd3, 8'h55);
      drain();
      chk("t6_beats", beats_seen - s, 7);
      chk("t6_last_empty", last_empty, 1);
      chk("t6_err_clean", proto_err_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
